ibex_prefetch_ctrl: RTL and testbench

Request scheduler for the instruction-side memory port. It issues word-aligned fetch requests, limits in-flight requests to `NUM_REQS`, and forwards responses into the fetch FIFO's input port. It also drives the FIFO clear on a branch and discards stale responses from requests issued before that branch. It sits between the core's fetch-enable/branch control and the instruction memory interface, alongside the fetch FIFO.

---
 rtl/ibex_prefetch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ibex_prefetch_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_prefetch_ctrl.sv
// Instruction-side fetch request scheduler: issues word-aligned requests, bounds in-flight requests,
// forwards responses to the fetch FIFO and drops responses made stale by a branch.
// Defining IBEX_PREFETCH_CTRL_DISCARD_CNT_EN adds a saturating dropped-response counter (discard_cnt_o).
module ibex_prefetch_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  output logic        fifo_clear_o,
  output logic        fifo_valid_o,
  output logic [31:0] fifo_addr_o,
  output logic [31:0] fifo_rdata_o,
  output logic        fifo_err_o,
  input  logic        fifo_ready_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
`ifdef IBEX_PREFETCH_CTRL_DISCARD_CNT_EN
  output logic [15:0] discard_cnt_o,
`endif
  output logic        busy_o
);

  localparam int unsigned     CntW     = $clog2(NUM_REQS + 1);
  localparam logic [CntW-1:0] MaxOutst = CntW'(NUM_REQS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_GNT_DISCARD
  } state_e;

  state_e          state_q, state_d;
  logic [29:0]     fetch_addr_q, fetch_addr_d;
  logic [29:0]     held_addr_q, held_addr_d;
  logic [29:0]     issue_addr;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic            idle;
  logic            gnt;
  logic            stale_gnt;

  // From IDLE the request is combinational; once presented it is held until granted.
  always_comb begin
    idle        = (state_q == IDLE);
    instr_req_o = 1'b0;
    issue_addr  = held_addr_q;
    if (idle) begin
      instr_req_o = req_i & (branch_i | fifo_ready_i) & (outst_q < MaxOutst);
      issue_addr  = branch_i ? addr_i[31:2] : fetch_addr_q;
    end else begin
      instr_req_o = 1'b1;
    end
  end

  assign instr_addr_o = {issue_addr, 2'b00};
  assign gnt          = instr_req_o & instr_gnt_i;
  assign stale_gnt    = gnt & ((state_q == WAIT_GNT_DISCARD) |
                               ((state_q == WAIT_GNT) & branch_i));

  always_comb begin
    state_d     = state_q;
    held_addr_d = held_addr_q;
    unique case (state_q)
      IDLE: begin
        if (instr_req_o && !instr_gnt_i) begin
          state_d     = WAIT_GNT;
          held_addr_d = issue_addr;
        end
      end
      WAIT_GNT: begin
        if (gnt) begin
          state_d = IDLE;
        end else if (branch_i) begin
          state_d = WAIT_GNT_DISCARD;
        end
      end
      WAIT_GNT_DISCARD: begin
        if (gnt) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A target issued and granted straight from IDLE has already been consumed.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (branch_i) begin
      fetch_addr_d = (idle && gnt) ? addr_i[31:2] + 30'd1 : addr_i[31:2];
    end else if (gnt && !stale_gnt) begin
      fetch_addr_d = issue_addr + 30'd1;
    end
  end

  // On a branch every response still owed becomes stale, except one arriving this cycle.
  always_comb begin
    outst_d = outst_q + CntW'(gnt) - CntW'(instr_rvalid_i);
    if (branch_i) begin
      discard_d = outst_q - CntW'(instr_rvalid_i) + CntW'(stale_gnt);
    end else begin
      discard_d = discard_q - CntW'(instr_rvalid_i && (discard_q != '0)) + CntW'(stale_gnt);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      held_addr_q  <= '0;
      outst_q      <= '0;
      discard_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      held_addr_q  <= held_addr_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
    end
  end

  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_valid_o = instr_rvalid_i & (discard_q == '0) & ~branch_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign busy_o       = instr_req_o | (outst_q != '0);

`ifdef IBEX_PREFETCH_CTRL_DISCARD_CNT_EN
  logic [15:0] discard_cnt_q;
  logic        drop;

  assign drop = instr_rvalid_i & (branch_i | (discard_q != '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      discard_cnt_q <= '0;
    end else if (drop && (discard_cnt_q != 16'hFFFF)) begin
      discard_cnt_q <= discard_cnt_q + 16'd1;
    end
  end

  assign discard_cnt_o = discard_cnt_q;
`endif

  rvalid_needs_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> (outst_q != '0));
  outst_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
    outst_q <= MaxOutst);
  discard_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
    discard_q <= outst_q);

endmodule

// File: tb/tb_ibex_prefetch_ctrl.sv
// Directed bench for ibex_prefetch_ctrl: a queue-based reference model is compared every cycle,
// with hand-computed literal checks at key points of each scenario.
module tb_ibex_prefetch_ctrl;

  localparam int NUM_REQS = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, branch_i, fifo_ready_i, instr_gnt_i, instr_rvalid_i, instr_err_i;
  logic [31:0] addr_i, instr_rdata_i;
  logic        fifo_clear_o, fifo_valid_o, fifo_err_o, instr_req_o, busy_o;
  logic [31:0] fifo_addr_o, fifo_rdata_o, instr_addr_o;
`ifdef IBEX_PREFETCH_CTRL_DISCARD_CNT_EN
  logic [15:0] discard_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  ibex_prefetch_ctrl #(.NUM_REQS(NUM_REQS)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .addr_i         (addr_i),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .fifo_err_o     (fifo_err_o),
    .fifo_ready_i   (fifo_ready_i),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
`ifdef IBEX_PREFETCH_CTRL_DISCARD_CNT_EN
    .discard_cnt_o  (discard_cnt_o),
`endif
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic b, input logic [31:0] a,
                               input logic rdy, input logic g, input logic rv,
                               input logic [31:0] d);
    @(posedge clk_i);
    #1;
    req_i          = r;
    branch_i       = b;
    addr_i         = a;
    fifo_ready_i   = rdy;
    instr_gnt_i    = g;
    instr_rvalid_i = rv;
    instr_rdata_i  = d;
    instr_err_i    = d[3];
  endtask

  // Reference model: a pending (ungranted) request plus a queue of in-flight requests, each
  // tagged stale or live. Responses return in order, so the queue head decides push vs drop.
  bit          m_q[$];
  bit          m_pend, m_pend_stale;
  logic [29:0] m_pend_addr, m_ptr;
  logic [15:0] m_drop;

  always @(negedge clk_i) begin
    logic        e_req, e_valid, g, stale, drop;
    logic [29:0] e_word;
    if (!rst_ni) begin
      m_q.delete();
      m_pend = 1'b0; m_pend_stale = 1'b0; m_pend_addr = '0; m_ptr = '0; m_drop = '0;
    end
    if (m_pend) begin
      e_req  = 1'b1;
      e_word = m_pend_addr;
    end else begin
      e_req  = req_i & (branch_i | fifo_ready_i) & (m_q.size() < NUM_REQS);
      e_word = branch_i ? addr_i[31:2] : m_ptr;
    end
    e_valid = instr_rvalid_i && !branch_i && (m_q.size() != 0) && !m_q[0];
    checkOutput("m_instr_req", instr_req_o, e_req);
    checkOutput("m_instr_addr", instr_addr_o, {e_word, 2'b00});
    checkOutput("m_fifo_clear", fifo_clear_o, branch_i);
    checkOutput("m_fifo_addr", fifo_addr_o, addr_i);
    checkOutput("m_fifo_valid", fifo_valid_o, e_valid);
    checkOutput("m_fifo_rdata", fifo_rdata_o, instr_rdata_i);
    checkOutput("m_fifo_err", fifo_err_o, instr_err_i);
    checkOutput("m_busy", busy_o, e_req | (m_q.size() != 0));
`ifdef IBEX_PREFETCH_CTRL_DISCARD_CNT_EN
    checkOutput("m_discard_cnt", discard_cnt_o, m_drop);
`endif
    if (rst_ni) begin
      g     = e_req & instr_gnt_i;
      stale = g & m_pend & (m_pend_stale | branch_i);
      drop  = instr_rvalid_i && (branch_i || (m_q.size() != 0 && m_q[0]));
      if (instr_rvalid_i && m_q.size() != 0) void'(m_q.pop_front());
      if (branch_i) foreach (m_q[i]) m_q[i] = 1'b1;
      if (g) m_q.push_back(stale);
      if (branch_i) m_ptr = (!m_pend && g) ? addr_i[31:2] + 30'd1 : addr_i[31:2];
      else if (g && !stale) m_ptr = e_word + 30'd1;
      if (g) m_pend = 1'b0;
      else if (e_req && !m_pend) begin
        m_pend = 1'b1; m_pend_addr = e_word; m_pend_stale = 1'b0;
      end else if (m_pend && branch_i) m_pend_stale = 1'b1;
      if (drop && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end
  end

  initial begin
    rst_ni = 1'b0;
    req_i = 0; branch_i = 0; addr_i = 32'h1234_5678; fifo_ready_i = 0;
    instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0; instr_err_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_instr_req", instr_req_o, 0);
    checkOutput("rst_instr_addr", instr_addr_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_fifo_valid", fifo_valid_o, 0);
    checkOutput("rst_fifo_clear", fifo_clear_o, 0);
    checkOutput("rst_fifo_addr", fifo_addr_o, 32'h1234_5678);
    @(posedge clk_i); #1 rst_ni = 1'b1;

    // Streaming from a branch to 0x100
    applyStimulus(1, 1, 32'h100, 1, 1, 0, 32'hD000_0000);
    #2 checkOutput("str_clear", fifo_clear_o, 1);
    checkOutput("str_addr0", instr_addr_o, 32'h100);
    applyStimulus(1, 0, 0, 1, 1, 1, 32'hD000_0100);
    #2 checkOutput("str_addr1", instr_addr_o, 32'h104);
    checkOutput("str_push1", fifo_valid_o, 1);
    applyStimulus(1, 0, 0, 1, 1, 1, 32'hD000_0104);
    #2 checkOutput("str_addr2", instr_addr_o, 32'h108);
    applyStimulus(1, 0, 0, 1, 1, 1, 32'hD000_0108);
    #2 checkOutput("str_addr3", instr_addr_o, 32'h10C);
    applyStimulus(0, 0, 0, 1, 0, 1, 32'hD000_010C);
    #2 checkOutput("str_tail_req", instr_req_o, 0);
    checkOutput("str_tail_busy", busy_o, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 32'h0);
    #2 checkOutput("str_idle_busy", busy_o, 0);

    // Full window: two grants, then no request until a response frees a slot
    applyStimulus(1, 0, 0, 1, 1, 0, 32'h0);
    #2 checkOutput("win_addr0", instr_addr_o, 32'h110);
    applyStimulus(1, 0, 0, 1, 1, 0, 32'h0);
    #2 checkOutput("win_addr1", instr_addr_o, 32'h114);
    applyStimulus(1, 0, 0, 1, 1, 0, 32'h0);
    #2 checkOutput("win_full_req", instr_req_o, 0);
    applyStimulus(1, 0, 0, 1, 0, 1, 32'hD000_0110);
    #2 checkOutput("win_rv_req", instr_req_o, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 32'h0);
    #2 checkOutput("win_reissue_req", instr_req_o, 1);
    checkOutput("win_reissue_addr", instr_addr_o, 32'h118);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    #2 checkOutput("win_hold_addr", instr_addr_o, 32'h118);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h0);

    // Branch to 0x2002 with two responses owed
    applyStimulus(1, 1, 32'h2002, 1, 0, 0, 32'h0);
    #2 checkOutput("br_clear", fifo_clear_o, 1);
    checkOutput("br_fifo_addr", fifo_addr_o, 32'h2002);
    checkOutput("br_full_req", instr_req_o, 0);
    applyStimulus(1, 0, 0, 1, 0, 1, 32'hBAD0_0114);
    #2 checkOutput("br_drop0", fifo_valid_o, 0);
    applyStimulus(1, 0, 0, 1, 1, 1, 32'hBAD0_0118);
    #2 checkOutput("br_drop1", fifo_valid_o, 0);
    checkOutput("br_target_addr", instr_addr_o, 32'h2000);
    applyStimulus(0, 0, 0, 1, 0, 1, 32'hD000_2000);
    #2 checkOutput("br_push", fifo_valid_o, 1);

    // Branch while waiting for grant on 0x40
    applyStimulus(1, 1, 32'h40, 1, 0, 0, 32'h0);
    #2 checkOutput("wg_addr", instr_addr_o, 32'h40);
    applyStimulus(1, 1, 32'h80, 1, 0, 0, 32'h0);
    #2 checkOutput("wg_held_on_br", instr_addr_o, 32'h40);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    #2 checkOutput("wg_held_req", instr_req_o, 1);
    applyStimulus(1, 0, 0, 1, 1, 0, 32'h0);
    applyStimulus(1, 0, 0, 1, 0, 1, 32'hBAD0_0040);
    #2 checkOutput("wg_drop", fifo_valid_o, 0);
    checkOutput("wg_target", instr_addr_o, 32'h80);
    applyStimulus(1, 0, 0, 1, 1, 0, 32'h0);
    applyStimulus(0, 0, 0, 1, 0, 1, 32'hD000_0080);
    #2 checkOutput("wg_push", fifo_valid_o, 1);

    // Branch and response in the same cycle with nothing yet discarded
    applyStimulus(1, 0, 0, 1, 1, 0, 32'h0);
    applyStimulus(1, 0, 0, 1, 1, 0, 32'h0);
    applyStimulus(0, 1, 32'h300, 1, 0, 1, 32'hBAD0_0084);
    #2 checkOutput("brv_no_push", fifo_valid_o, 0);
    checkOutput("brv_addr", instr_addr_o, 32'h300);
    applyStimulus(0, 0, 0, 1, 0, 1, 32'hBAD0_0088);
    #2 checkOutput("brv_drop", fifo_valid_o, 0);
    checkOutput("brv_busy", busy_o, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 32'h0);

    // Branch coinciding with the grant of a held request
    applyStimulus(1, 0, 0, 1, 0, 0, 32'h0);
    applyStimulus(1, 1, 32'h500, 1, 1, 0, 32'h0);
    #2 checkOutput("bg_held_addr", instr_addr_o, 32'h300);
    applyStimulus(1, 0, 0, 1, 1, 1, 32'hBAD0_0300);
    #2 checkOutput("bg_target", instr_addr_o, 32'h500);
    checkOutput("bg_drop", fifo_valid_o, 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 32'hD000_0500);
    #2 checkOutput("bg_push", fifo_valid_o, 1);

    // Address wrap at the top of memory
    applyStimulus(1, 1, 32'hFFFF_FFFC, 1, 1, 0, 32'h0);
    applyStimulus(1, 0, 0, 1, 0, 1, 32'hD0FF_FFFC);
    #2 checkOutput("wrap_addr", instr_addr_o, 32'h0);
    applyStimulus(1, 0, 0, 1, 1, 0, 32'h0);
    applyStimulus(0, 0, 0, 1, 0, 1, 32'hD000_0000);

`ifdef IBEX_PREFETCH_CTRL_DISCARD_CNT_EN
    #2 checkOutput("discard_cnt", discard_cnt_o, 6);
`endif

    // Reset in the middle of a transaction
    applyStimulus(1, 0, 0, 1, 1, 0, 32'h0);
    #2 checkOutput("mr_addr", instr_addr_o, 32'h4);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    req_i = 0; branch_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0;
    #1 checkOutput("mr_busy", busy_o, 0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    applyStimulus(1, 0, 0, 1, 0, 0, 32'h0);
    #2 checkOutput("mr_restart_addr", instr_addr_o, 32'h0);
    checkOutput("mr_restart_req", instr_req_o, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hD000_0000);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
